// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - road-state codes, default thresholds and level helper
package traffic_pkg;

  // Thermometer road-state codes shared with the level1 controller
  localparam logic [2:0] RD_EMPTY = 3'b000;
  localparam logic [2:0] RD_LESS  = 3'b001;
  localparam logic [2:0] RD_MORE  = 3'b011;
  localparam logic [2:0] RD_FULL  = 3'b111;

  // Default occupancy capacity, level thresholds and filter hold length
  localparam int CAP     = 32;
  localparam int MORE_TH = 12;
  localparam int FULL_TH = 24;
  localparam int HOLD    = 4;

  typedef enum logic {
    F_STABLE,
    F_PENDING
  } filt_state_t;

  // Map an occupancy count onto its unfiltered road-state code
  function automatic logic [2:0] raw_level(input logic [5:0] cnt,
                                           input int more_th,
                                           input int full_th);
    if (cnt == 6'd0) begin
      return RD_EMPTY;
    end else if (int'(cnt) < more_th) begin
      return RD_LESS;
    end else if (int'(cnt) < full_th) begin
      return RD_MORE;
    end else begin
      return RD_FULL;
    end
  endfunction

endpackage

// File: rtl/sensor_filter.sv
// rtl/sensor_filter.sv - hold filter turning the raw level into a debounced S
module sensor_filter
  import traffic_pkg::*;
#(
  parameter int HOLD = traffic_pkg::HOLD
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [2:0] raw,
  output logic [2:0] S,
  output logic       changed
);

  // hold_cnt only ever reaches HOLD-1, so $clog2(HOLD) bits are enough
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] LAST = HW'(HOLD - 1);

  filt_state_t   state;
  logic [2:0]    cand;
  logic [HW-1:0] hold_cnt;

  // Accept a new level only after it has been steady for HOLD edges
  always_ff @(posedge clock) begin
    if (!clear) begin
      state    <= F_STABLE;
      S        <= RD_EMPTY;
      cand     <= RD_EMPTY;
      hold_cnt <= '0;
      changed  <= 1'b0;
    end else begin
      changed <= 1'b0;
      case (state)
        F_STABLE: begin
          if (raw != S) begin
            if (HOLD == 1) begin
              S       <= raw;
              changed <= 1'b1;
            end else begin
              state    <= F_PENDING;
              cand     <= raw;
              hold_cnt <= HW'(1);
            end
          end
        end
        F_PENDING: begin
          if (raw == S) begin
            // Level fell back before settling: drop the candidate silently
            state    <= F_STABLE;
            hold_cnt <= '0;
          end else if (raw == cand) begin
            if (hold_cnt == LAST) begin
              S        <= cand;
              changed  <= 1'b1;
              state    <= F_STABLE;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end else begin
            // A different level appeared: start timing it from scratch
            cand     <= raw;
            hold_cnt <= HW'(1);
          end
        end
        default: begin
          state    <= F_STABLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/road_sensor.sv
// rtl/road_sensor.sv - vehicle occupancy counter with filtered road-state output
module road_sensor
  import traffic_pkg::*;
#(
  parameter int CAP     = traffic_pkg::CAP,
  parameter int MORE_TH = traffic_pkg::MORE_TH,
  parameter int FULL_TH = traffic_pkg::FULL_TH,
  parameter int HOLD    = traffic_pkg::HOLD
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       car_in,
  input  logic       car_out,
  output logic [2:0] S,
  output logic [5:0] count,
  output logic       changed,
  output logic       ovf
);

  logic       car_in_q;
  logic       car_out_q;
  logic       in_evt;
  logic       out_evt;
  logic [2:0] raw;

  assign in_evt  = car_in & ~car_in_q;
  assign out_evt = car_out & ~car_out_q;
  assign raw     = raw_level(count, MORE_TH, FULL_TH);

  // Track detector edges and keep a saturating occupancy count
  always_ff @(posedge clock) begin
    if (!clear) begin
      car_in_q  <= 1'b0;
      car_out_q <= 1'b0;
      count     <= 6'd0;
      ovf       <= 1'b0;
    end else begin
      car_in_q  <= car_in;
      car_out_q <= car_out;
      if (in_evt && !out_evt) begin
        if (count == 6'(CAP)) begin
          ovf <= 1'b1;
        end else begin
          count <= count + 6'd1;
        end
      end else if (out_evt && !in_evt) begin
        if (count == 6'd0) begin
          ovf <= 1'b1;
        end else begin
          count <= count - 6'd1;
        end
      end
    end
  end

  sensor_filter #(
    .HOLD(HOLD)
  ) u_filter (
    .clock  (clock),
    .clear  (clear),
    .raw    (raw),
    .S      (S),
    .changed(changed)
  );

endmodule

// File: tb/tb_road_sensor.sv
// tb/tb_road_sensor.sv - directed self-checking bench for road_sensor
module tb_road_sensor;

  localparam int HOLD = 4;

  logic       clock;
  logic       clear;
  logic       car_in;
  logic       car_out;
  logic [2:0] S;
  logic [5:0] count;
  logic       changed;
  logic       ovf;

  int passed;
  int total;

  logic       mon_clr;
  int         chg_cnt;
  int         bad_code;
  int         short_hold;
  int         run_len;
  logic [2:0] prev_s;

  road_sensor dut (
    .clock  (clock),
    .clear  (clear),
    .car_in (car_in),
    .car_out(car_out),
    .S      (S),
    .count  (count),
    .changed(changed),
    .ovf    (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observe S like level1 would: legal codes only, each held HOLD cycles
  always @(negedge clock) begin
    if (mon_clr) begin
      chg_cnt    = 0;
      bad_code   = 0;
      short_hold = 0;
      run_len    = 100;
      prev_s     = S;
    end else begin
      if (changed) chg_cnt = chg_cnt + 1;
      if (!(S == 3'b000 || S == 3'b001 || S == 3'b011 || S == 3'b111))
        bad_code = bad_code + 1;
      if (S != prev_s) begin
        if (run_len < HOLD) short_hold = short_hold + 1;
        run_len = 1;
      end else begin
        run_len = run_len + 1;
      end
      prev_s = S;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear   = 1'b0;
    car_in  = 1'b0;
    car_out = 1'b0;
    step();
    step();
    clear = 1'b1;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic add_cars(input int n);
    for (int i = 0; i < n; i++) begin
      car_in = 1'b1;
      step();
      car_in = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count !== 6'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
    total++; if (S !== 3'b000) $display("FAIL reset_S: got %b expected 000", S); else passed++;
    total++; if (changed !== 1'b0) $display("FAIL reset_changed: got %b expected 0", changed); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else passed++;
  endtask

  task automatic test_single_entry();
    do_reset();
    car_in = 1'b1;
    step();
    total++; if (count !== 6'd1) $display("FAIL single_count_e1: got %0d expected 1", count); else passed++;
    step();
    step();
    car_in = 1'b0;
    step();
    total++; if (S !== 3'b000) $display("FAIL single_S_e4: got %b expected 000", S); else passed++;
    step();
    total++; if (S !== 3'b001) $display("FAIL single_S_e5: got %b expected 001", S); else passed++;
    total++; if (changed !== 1'b1) $display("FAIL single_changed_e5: got %b expected 1", changed); else passed++;
    step();
    total++; if (changed !== 1'b0) $display("FAIL single_changed_e6: got %b expected 0", changed); else passed++;
    total++; if (count !== 6'd1) $display("FAIL single_count_e6: got %0d expected 1", count); else passed++;
  endtask

  task automatic test_less_to_more();
    do_reset();
    mon_clear();
    add_cars(12);
    step();
    step();
    total++; if (S !== 3'b001) $display("FAIL l2m_S_before: got %b expected 001", S); else passed++;
    step();
    total++; if (S !== 3'b011) $display("FAIL l2m_S_after: got %b expected 011", S); else passed++;
    total++; if (changed !== 1'b1) $display("FAIL l2m_changed: got %b expected 1", changed); else passed++;
    total++; if (count !== 6'd12) $display("FAIL l2m_count: got %0d expected 12", count); else passed++;
    step();
    total++; if (chg_cnt !== 2) $display("FAIL l2m_pulses: got %0d expected 2", chg_cnt); else passed++;
  endtask

  task automatic test_flicker();
    do_reset();
    add_cars(11);
    repeat (8) step();
    total++; if (S !== 3'b001) $display("FAIL flick_S_start: got %b expected 001", S); else passed++;
    mon_clear();
    car_in = 1'b1;
    step();
    total++; if (count !== 6'd12) $display("FAIL flick_count_up: got %0d expected 12", count); else passed++;
    car_in = 1'b0;
    step();
    car_out = 1'b1;
    step();
    total++; if (count !== 6'd11) $display("FAIL flick_count_down: got %0d expected 11", count); else passed++;
    car_out = 1'b0;
    repeat (8) step();
    total++; if (S !== 3'b001) $display("FAIL flick_S_end: got %b expected 001", S); else passed++;
    total++; if (chg_cnt !== 0) $display("FAIL flick_pulses: got %0d expected 0", chg_cnt); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    add_cars(32);
    total++; if (count !== 6'd32) $display("FAIL sat_count_full: got %0d expected 32", count); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL sat_ovf_before: got %b expected 0", ovf); else passed++;
    add_cars(1);
    total++; if (count !== 6'd32) $display("FAIL sat_count_over: got %0d expected 32", count); else passed++;
    total++; if (ovf !== 1'b1) $display("FAIL sat_ovf_over: got %b expected 1", ovf); else passed++;
    do_reset();
    car_out = 1'b1;
    step();
    car_out = 1'b0;
    step();
    total++; if (count !== 6'd0) $display("FAIL sat_count_under: got %0d expected 0", count); else passed++;
    total++; if (ovf !== 1'b1) $display("FAIL sat_ovf_under: got %b expected 1", ovf); else passed++;
    do_reset();
    add_cars(5);
    car_in  = 1'b1;
    car_out = 1'b1;
    step();
    total++; if (count !== 6'd5) $display("FAIL sat_count_both: got %0d expected 5", count); else passed++;
    car_in  = 1'b0;
    car_out = 1'b0;
    step();
    total++; if (ovf !== 1'b0) $display("FAIL sat_ovf_both: got %b expected 0", ovf); else passed++;
    total++; if (count !== 6'd5) $display("FAIL sat_count_both_after: got %0d expected 5", count); else passed++;
  endtask

  task automatic test_reset_pending();
    do_reset();
    add_cars(23);
    repeat (6) step();
    total++; if (S !== 3'b011) $display("FAIL rp_S_more: got %b expected 011", S); else passed++;
    car_in = 1'b1;
    step();
    car_in = 1'b0;
    total++; if (count !== 6'd24) $display("FAIL rp_count_24: got %0d expected 24", count); else passed++;
    step();
    clear = 1'b0;
    step();
    total++; if (count !== 6'd0) $display("FAIL rp_count: got %0d expected 0", count); else passed++;
    total++; if (S !== 3'b000) $display("FAIL rp_S: got %b expected 000", S); else passed++;
    total++; if (changed !== 1'b0) $display("FAIL rp_changed: got %b expected 0", changed); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL rp_ovf: got %b expected 0", ovf); else passed++;
    clear = 1'b1;
    repeat (6) step();
    total++; if (S !== 3'b000) $display("FAIL rp_S_abandoned: got %b expected 000", S); else passed++;
    clear  = 1'b0;
    car_in = 1'b1;
    step();
    total++; if (count !== 6'd0) $display("FAIL rp_count_in_reset: got %0d expected 0", count); else passed++;
    clear = 1'b1;
    step();
    total++; if (count !== 6'd1) $display("FAIL rp_count_high_release: got %0d expected 1", count); else passed++;
    car_in = 1'b0;
    step();
  endtask

  task automatic test_level1();
    do_reset();
    mon_clear();
    add_cars(24);
    repeat (8) step();
    total++; if (S !== 3'b111) $display("FAIL l1_S_full: got %b expected 111", S); else passed++;
    total++; if (count !== 6'd24) $display("FAIL l1_count: got %0d expected 24", count); else passed++;
    total++; if (chg_cnt !== 3) $display("FAIL l1_pulses: got %0d expected 3", chg_cnt); else passed++;
    total++; if (bad_code !== 0) $display("FAIL l1_bad_codes: got %0d expected 0", bad_code); else passed++;
    total++; if (short_hold !== 0) $display("FAIL l1_short_holds: got %0d expected 0", short_hold); else passed++;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    mon_clr = 1'b1;
    clear   = 1'b0;
    car_in  = 1'b0;
    car_out = 1'b0;
    test_reset();
    mon_clr = 1'b0;
    test_single_entry();
    test_less_to_more();
    test_flicker();
    test_saturation();
    test_reset_pending();
    test_level1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
